// File: rtl/trd_pc_sched.sv
// Per-thread PC file and round-robin scheduler for the 8-thread barrel core.
// Tracks miss-blocked threads and issues one ready thread per cycle to fetch.
module trd_pc_sched #(
  parameter logic [31:0] START_PC = 32'h0000_0000,
  parameter int          NUM_TRD  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] nxt_pc_0,
  input  logic [31:0] nxt_pc_1,
  input  logic [31:0] nxt_pc_2,
  input  logic [31:0] nxt_pc_3,
  input  logic [31:0] nxt_pc_4,
  input  logic [31:0] nxt_pc_5,
  input  logic [31:0] nxt_pc_6,
  input  logic [31:0] nxt_pc_7,
  input  logic [7:0]  pc_wr,
  input  logic [7:0]  trd_en,
  input  logic        i_miss,
  input  logic [2:0]  i_miss_trd,
  input  logic        d_miss,
  input  logic [2:0]  d_miss_trd,
  input  logic        i_fill_done,
  input  logic [2:0]  i_fill_trd,
  input  logic        d_fill_done,
  input  logic [2:0]  d_fill_trd,
  input  logic        stall,
  output logic [2:0]  cur_trd,
  output logic [31:0] cur_pc,
  output logic        cur_vld,
  output logic [7:0]  blocked
);

  logic [31:0] pc     [NUM_TRD];
  logic [31:0] nxt_pc [NUM_TRD];
  logic [2:0]  rr_ptr;
  logic [7:0]  mset;
  logic [7:0]  mclr;
  logic [7:0]  ready;
  logic [2:0]  sel;
  logic        any_rdy;
  logic [31:0] spc;

  assign nxt_pc[0] = nxt_pc_0;
  assign nxt_pc[1] = nxt_pc_1;
  assign nxt_pc[2] = nxt_pc_2;
  assign nxt_pc[3] = nxt_pc_3;
  assign nxt_pc[4] = nxt_pc_4;
  assign nxt_pc[5] = nxt_pc_5;
  assign nxt_pc[6] = nxt_pc_6;
  assign nxt_pc[7] = nxt_pc_7;

  always_comb begin
    mset = '0;
    mclr = '0;
    if (i_miss)      mset[i_miss_trd] = 1'b1;
    if (d_miss)      mset[d_miss_trd] = 1'b1;
    if (i_fill_done) mclr[i_fill_trd] = 1'b1;
    if (d_fill_done) mclr[d_fill_trd] = 1'b1;
  end

  // A miss this cycle removes its thread immediately; a fill only acts via blocked.
  assign ready   = trd_en & ~blocked & ~mset;
  assign any_rdy = |ready;

  always_comb begin
    logic       found;
    logic [2:0] idx;
    sel   = rr_ptr;
    found = 1'b0;
    idx   = rr_ptr;
    for (int k = 1; k <= NUM_TRD; k++) begin
      idx = rr_ptr + 3'(k);
      if (!found && ready[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Bypass lets a lone runnable thread issue back-to-back with its fresh PC.
  assign spc = pc_wr[sel] ? nxt_pc[sel] : pc[sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TRD; i++) pc[i] <= START_PC;
      blocked <= '0;
    end else begin
      for (int i = 0; i < NUM_TRD; i++) begin
        if (pc_wr[i]) pc[i] <= nxt_pc[i];
      end
      blocked <= (blocked & ~mclr) | mset;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= 3'd7;
      cur_trd <= 3'd0;
      cur_pc  <= START_PC;
      cur_vld <= 1'b0;
    end else if (stall) begin
      // Held slot still tracks redirects and is killed if its thread misses.
      if (pc_wr[cur_trd]) cur_pc <= nxt_pc[cur_trd];
      cur_vld <= cur_vld & ~mset[cur_trd];
    end else if (any_rdy) begin
      rr_ptr  <= sel;
      cur_trd <= sel;
      cur_pc  <= spc;
      cur_vld <= 1'b1;
    end else begin
      cur_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trd_pc_sched.sv
// Bench for trd_pc_sched: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_trd_pc_sched;

  localparam logic [31:0] SPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] nxt [8];
  logic [7:0]  pc_wr = '0;
  logic [7:0]  trd_en = '0;
  logic        i_miss = 1'b0;
  logic [2:0]  i_miss_trd = '0;
  logic        d_miss = 1'b0;
  logic [2:0]  d_miss_trd = '0;
  logic        i_fill_done = 1'b0;
  logic [2:0]  i_fill_trd = '0;
  logic        d_fill_done = 1'b0;
  logic [2:0]  d_fill_trd = '0;
  logic        stall = 1'b0;
  logic [2:0]  cur_trd;
  logic [31:0] cur_pc;
  logic        cur_vld;
  logic [7:0]  blocked;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  trd_pc_sched #(.START_PC(SPC), .NUM_TRD(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .nxt_pc_0(nxt[0]), .nxt_pc_1(nxt[1]), .nxt_pc_2(nxt[2]), .nxt_pc_3(nxt[3]),
    .nxt_pc_4(nxt[4]), .nxt_pc_5(nxt[5]), .nxt_pc_6(nxt[6]), .nxt_pc_7(nxt[7]),
    .pc_wr(pc_wr), .trd_en(trd_en),
    .i_miss(i_miss), .i_miss_trd(i_miss_trd), .d_miss(d_miss), .d_miss_trd(d_miss_trd),
    .i_fill_done(i_fill_done), .i_fill_trd(i_fill_trd),
    .d_fill_done(d_fill_done), .d_fill_trd(d_fill_trd),
    .stall(stall), .cur_trd(cur_trd), .cur_pc(cur_pc), .cur_vld(cur_vld),
    .blocked(blocked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Behavioural reference model
  logic [31:0] m_pc [8] = '{default: SPC};
  logic [7:0]  m_blk = '0;
  int          m_rr = 7;
  logic [2:0]  e_trd = '0;
  logic [31:0] e_pc = SPC;
  logic        e_vld = 1'b0;

  function automatic logic [7:0] ev_mask(input logic a, input logic [2:0] ta,
                                         input logic b, input logic [2:0] tb);
    logic [7:0] m;
    m = '0;
    if (a) m = m | (8'd1 << ta);
    if (b) m = m | (8'd1 << tb);
    return m;
  endfunction

  function automatic int pick_next(input logic [7:0] rdy, input int rr);
    for (int k = 1; k <= 8; k++) begin
      if (rdy[(rr + k) % 8]) return (rr + k) % 8;
    end
    return -1;
  endfunction

  logic [7:0] m_set;
  logic [7:0] m_clr;
  int         m_sel;
  assign m_set = ev_mask(i_miss, i_miss_trd, d_miss, d_miss_trd);
  assign m_clr = ev_mask(i_fill_done, i_fill_trd, d_fill_done, d_fill_trd);
  assign m_sel = pick_next(trd_en & ~m_blk & ~m_set, m_rr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_pc[i] <= SPC;
      m_blk <= '0;
      m_rr  <= 7;
      e_trd <= '0;
      e_pc  <= SPC;
      e_vld <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) if (pc_wr[i]) m_pc[i] <= nxt[i];
      m_blk <= (m_blk & ~m_clr) | m_set;
      if (stall) begin
        if (pc_wr[e_trd]) e_pc <= nxt[e_trd];
        e_vld <= e_vld && !m_set[e_trd];
      end else if (m_sel >= 0) begin
        e_trd <= 3'(m_sel);
        e_pc  <= pc_wr[m_sel] ? nxt[m_sel] : m_pc[m_sel];
        e_vld <= 1'b1;
        m_rr  <= m_sel;
      end else begin
        e_vld <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("model_cur_vld", 32'(cur_vld), 32'(e_vld));
      chk("model_cur_trd", 32'(cur_trd), 32'(e_trd));
      chk("model_cur_pc", cur_pc, e_pc);
      chk("model_blocked", 32'(blocked), 32'(m_blk));
    end
  end

  task automatic idle_inputs();
    pc_wr = '0; i_miss = 0; d_miss = 0; i_fill_done = 0; d_fill_done = 0; stall = 0;
  endtask

  int seq4 [5] = '{6, 7, 0, 1, 2};

  initial begin
    for (int i = 0; i < 8; i++) nxt[i] = '0;
    idle_inputs();
    trd_en = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_cur_vld", 32'(cur_vld), 0);
    chk("rst_cur_trd", 32'(cur_trd), 0);
    chk("rst_cur_pc", cur_pc, SPC);
    chk("rst_blocked", 32'(blocked), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // all threads enabled: plain rotation from thread 0
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("rot_trd", 32'(cur_trd), i % 8);
      chk("rot_vld", 32'(cur_vld), 1);
      chk("rot_pc", cur_pc, SPC);
    end

    // two threads alternate, then nothing enabled
    trd_en = 8'b0000_0101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_trd", 32'(cur_trd), (i % 2 == 0) ? 2 : 0);
    end
    trd_en = 8'h00;
    @(negedge clk);
    chk("none_vld", 32'(cur_vld), 0);
    chk("none_trd_hold", 32'(cur_trd), 0);

    // single thread issues back-to-back through the PC bypass
    trd_en = 8'h08;
    @(negedge clk);
    chk("single_trd", 32'(cur_trd), 3);
    chk("single_pc0", cur_pc, SPC);
    for (int k = 1; k <= 4; k++) begin
      pc_wr = 8'h08;
      nxt[3] = cur_pc + 32'd1;
      @(negedge clk);
      chk("bypass_trd", 32'(cur_trd), 3);
      chk("bypass_vld", 32'(cur_vld), 1);
      chk("bypass_pc", cur_pc, SPC + 32'(k));
    end
    pc_wr = '0;

    // miss blocking, set-wins collision, fill release
    trd_en = 8'hFF;
    repeat (6) @(negedge clk);
    chk("pre_miss_trd", 32'(cur_trd), 1);
    d_miss = 1; d_miss_trd = 3'd2;
    @(negedge clk);
    chk("miss_skip_trd", 32'(cur_trd), 3);
    chk("miss_blocked", 32'(blocked), 32'h04);
    d_fill_done = 1; d_fill_trd = 3'd2;
    @(negedge clk);
    chk("collide_trd", 32'(cur_trd), 4);
    chk("collide_blocked", 32'(blocked), 32'h04);
    d_miss = 0;
    @(negedge clk);
    chk("fill_trd", 32'(cur_trd), 5);
    chk("fill_blocked", 32'(blocked), 0);
    d_fill_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_fill_trd", 32'(cur_trd), seq4[i]);
    end

    // stall holds the slot, tracks redirect, kills on miss
    repeat (3) @(negedge clk);
    chk("pre_stall_trd", 32'(cur_trd), 5);
    stall = 1;
    @(negedge clk);
    chk("stall_trd", 32'(cur_trd), 5);
    chk("stall_vld", 32'(cur_vld), 1);
    pc_wr = 8'h20; nxt[5] = 32'h40;
    @(negedge clk);
    chk("stall_redirect_pc", cur_pc, 32'h40);
    chk("stall_redirect_trd", 32'(cur_trd), 5);
    pc_wr = '0; d_miss = 1; d_miss_trd = 3'd5;
    @(negedge clk);
    chk("stall_kill_vld", 32'(cur_vld), 0);
    chk("stall_kill_trd", 32'(cur_trd), 5);
    stall = 0; d_miss = 0;
    @(negedge clk);
    chk("resume_trd", 32'(cur_trd), 6);
    chk("resume_vld", 32'(cur_vld), 1);
    d_fill_done = 1; d_fill_trd = 3'd5;
    @(negedge clk);
    d_fill_done = 0;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      trd_en      = 8'($urandom) | 8'($urandom);
      pc_wr       = 8'($urandom) & 8'($urandom);
      for (int i = 0; i < 8; i++) nxt[i] = $urandom;
      i_miss      = ($urandom_range(0, 3) == 0);
      i_miss_trd  = 3'($urandom);
      d_miss      = ($urandom_range(0, 3) == 0);
      d_miss_trd  = 3'($urandom);
      i_fill_done = ($urandom_range(0, 2) == 0);
      i_fill_trd  = 3'($urandom);
      d_fill_done = ($urandom_range(0, 2) == 0);
      d_fill_trd  = 3'($urandom);
      stall       = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end

    // asynchronous reset mid-run
    idle_inputs();
    trd_en = 8'hFF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 32'(cur_vld), 0);
    chk("async_rst_pc", cur_pc, SPC);
    chk("async_rst_blocked", 32'(blocked), 0);
    chk("async_rst_trd", 32'(cur_trd), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_trd", 32'(cur_trd), 0);
    chk("post_rst_vld", 32'(cur_vld), 1);
    chk("post_rst_pc", cur_pc, SPC);
    @(negedge clk);
    chk("post_rst_trd2", 32'(cur_trd), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
